// File: rtl/datapath_pkg.sv
// Shared constants for the Mini-SRC Phase-2 datapath: data width, ALU opcodes
// (IR[31:27]) and CON condition codes (IR[20:19]).
package datapath_pkg;
  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] CON_ZERO = 2'b00;
  localparam logic [1:0] CON_NZ   = 2'b01;
  localparam logic [1:0] CON_POS  = 2'b10;
  localparam logic [1:0] CON_NEG  = 2'b11;
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result {Zhigh, Zlow}.
// Signed mul/div only when MUL_DIV_EN is defined; otherwise those opcodes add.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [4:0]          op_i,
  input  logic                inc_i,
  output logic [2*DATA_W-1:0] z_o
);
  logic [4:0]          shamt;
  logic [2*DATA_W-1:0] rot_r, rot_l;

  assign shamt = b_i[4:0];
  // Rotates via a doubled operand so a zero shift amount needs no special case.
  assign rot_r = {a_i, a_i} >> shamt;
  assign rot_l = {a_i, a_i} << shamt;

`ifdef MUL_DIV_EN
  logic signed [2*DATA_W-1:0] sa, sb, prod;
  logic signed [DATA_W-1:0]   quot, rem;
  assign sa   = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign sb   = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign prod = sa * sb;
  assign quot = (b_i == '0) ? '0 : $signed(a_i) / $signed(b_i);
  assign rem  = (b_i == '0) ? '0 : $signed(a_i) % $signed(b_i);
`endif

  always_comb begin
    z_o = '0;
    if (inc_i) begin
      z_o[DATA_W-1:0] = b_i + 1'b1;
    end else begin
      unique case (op_i)
        OP_SUB:          z_o[DATA_W-1:0] = a_i - b_i;
        OP_AND, OP_ANDI: z_o[DATA_W-1:0] = a_i & b_i;
        OP_OR,  OP_ORI:  z_o[DATA_W-1:0] = a_i | b_i;
        OP_SHR:          z_o[DATA_W-1:0] = a_i >> shamt;
        OP_SHRA:         z_o[DATA_W-1:0] = DATA_W'($signed(a_i) >>> shamt);
        OP_SHL:          z_o[DATA_W-1:0] = a_i << shamt;
        OP_ROR:          z_o[DATA_W-1:0] = rot_r[DATA_W-1:0];
        OP_ROL:          z_o[DATA_W-1:0] = rot_l[2*DATA_W-1:DATA_W];
        OP_NEG:          z_o[DATA_W-1:0] = -b_i;
        OP_NOT:          z_o[DATA_W-1:0] = ~b_i;
`ifdef MUL_DIV_EN
        OP_MUL:          z_o = prod;
        OP_DIV:          z_o = {rem, quot};
`endif
        default:         z_o[DATA_W-1:0] = a_i + b_i;
      endcase
    end
  end
endmodule

// File: rtl/datapath_p2.sv
// Mini-SRC Phase-2 single-bus datapath; every transfer is a one-hot strobe, loads land one edge later.
// Optional signed mul/div in the ALU is enabled with `define MUL_DIV_EN.
module datapath_p2
  import datapath_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int RAM_AW = 9
) (
  input  logic              Clock,
  input  logic              Clear,
  output logic [DATA_W-1:0] outp,
  output logic              BranchMet,
  input  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
  input  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
  input  logic IncPC, Read, Write, MemSel,
  input  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic [DATA_W-1:0] InPort_data
);
  logic [DATA_W-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, in_q, out_q;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic                con_q, con_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   ram_q  [2**RAM_AW];

  logic [NREGS-1:0]    reg_sel;
  logic [DATA_W-1:0]   reg_dat, csext, bus, ram_rd, mdr_d;
  logic                reg_is_r0, reg_found;
  logic                unused_mar;

  assign csext      = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};
  assign ram_rd     = ram_q[mar_q[RAM_AW-1:0]];
  assign unused_mar = ^mar_q[DATA_W-1:RAM_AW];

  always_comb begin
    reg_sel = '0;
    if (Gra) reg_sel[ir_q[26:23]] = 1'b1;
    if (Grb) reg_sel[ir_q[22:19]] = 1'b1;
    if (Grc) reg_sel[ir_q[18:15]] = 1'b1;
  end

  // Lowest-numbered selected register drives Rout/BAout.
  always_comb begin
    reg_dat   = '0;
    reg_is_r0 = 1'b0;
    reg_found = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (reg_sel[i] && !reg_found) begin
        reg_found = 1'b1;
        reg_dat   = regs_q[i];
        reg_is_r0 = (i == 0);
      end
    end
  end

  always_comb begin
    bus = '0;
    if      (PCout)     bus = pc_q;
    else if (Zhiout)    bus = z_q[2*DATA_W-1:DATA_W];
    else if (Zlowout)   bus = z_q[DATA_W-1:0];
    else if (MDRout)    bus = mdr_q;
    else if (HIout)     bus = hi_q;
    else if (LOout)     bus = lo_q;
    else if (InPortout) bus = in_q;
    else if (Cout)      bus = csext;
    else if (Rout)      bus = reg_dat;
    else if (BAout)     bus = reg_is_r0 ? '0 : reg_dat;
  end

  always_comb begin
    mdr_d = Read ? (MemSel ? ram_rd : Mdatain) : bus;
    unique case (ir_q[20:19])
      CON_ZERO: con_d = (bus == '0);
      CON_NZ:   con_d = (bus != '0);
      CON_POS:  con_d = ~bus[DATA_W-1];
      default:  con_d = bus[DATA_W-1];
    endcase
  end

  datapath_alu u_alu (
    .a_i  (y_q),
    .b_i  (bus),
    .op_i (ir_q[31:27]),
    .inc_i(IncPC),
    .z_o  (z_d)
  );

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      pc_q  <= '0; ir_q <= '0; mar_q <= '0; mdr_q <= '0; y_q <= '0;
      z_q   <= '0; hi_q <= '0; lo_q  <= '0; in_q  <= '0; out_q <= '0;
      con_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (PCin)      pc_q  <= bus;
      if (IRin)      ir_q  <= bus;
      if (MARin)     mar_q <= bus;
      if (MDRin)     mdr_q <= mdr_d;
      if (Yin)       y_q   <= bus;
      if (Zin)       z_q   <= z_d;
      if (HIin)      hi_q  <= bus;
      if (LOin)      lo_q  <= bus;
      if (Strobe)    in_q  <= InPort_data;
      if (OutPortin) out_q <= bus;
      if (CONIn)     con_q <= con_d;
      for (int i = 0; i < NREGS; i++)
        if (Rin && reg_sel[i]) regs_q[i] <= bus;
    end
  end

  // RAM has no reset so memory images survive Clear.
  always_ff @(posedge Clock) begin
    if (Write) ram_q[mar_q[RAM_AW-1:0]] <= mdr_q;
  end

  assign outp      = out_q;
  assign BranchMet = con_q;
endmodule

// File: tb/tb_datapath_p2.sv
// Directed bench for datapath_p2: values reach outp via OutPortin, checked with immediate asserts.
module tb_datapath_p2;
  import datapath_pkg::*;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] outp;
  logic        BranchMet;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write, MemSel;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic [31:0] Mdatain, InPort_data;

  int checks = 0;
  int errors = 0;

  datapath_p2 dut (
    .Clock(Clock), .Clear(Clear), .outp(outp), .BranchMet(BranchMet),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .MemSel(MemSel),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONIn(CONIn), .Strobe(Strobe),
    .Mdatain(Mdatain), .InPort_data(InPort_data)
  );

  always #5 Clock = ~Clock;

  task automatic clr_ctl();
    PCout = 0; Zhiout = 0; Zlowout = 0; MDRout = 0; HIout = 0; LOout = 0; InPortout = 0;
    MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
    OutPortin = 0; IncPC = 0; Read = 0; Write = 0; MemSel = 0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0; Cout = 0; CONIn = 0; Strobe = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctl();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sets the bus source(s); this latches the bus into OutPort and checks it.
  task automatic show(input string tag, input logic [31:0] exp);
    OutPortin = 1;
    tick();
    chk(tag, outp, exp);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc,
                                        input logic [14:0] low);
    return {op, ra, rb, rc, low};
  endfunction

  task automatic put_in(input logic [31:0] v);
    InPort_data = v; Strobe = 1;
    tick();
  endtask

  task automatic load_ir(input logic [31:0] v);
    put_in(v);
    InPortout = 1; IRin = 1;
    tick();
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
    load_ir(mk_ir(5'b00000, idx, 4'd0, 4'd0, 15'd0));
    put_in(v);
    InPortout = 1; Gra = 1; Rin = 1;
    tick();
  endtask

  // Y <- R[ry], Z <- Y op R[rb], then check both halves of Z.
  task automatic alu_chk(input string tag, input logic [4:0] op, input logic [3:0] ry,
                         input logic [3:0] rb, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    load_ir(mk_ir(op, 4'd0, ry, rb, 15'd0));
    Grb = 1; Rout = 1; Yin = 1;
    tick();
    Grc = 1; Rout = 1; Zin = 1;
    tick();
    Zlowout = 1; show({tag, "_lo"}, exp_lo);
    Zhiout = 1;  show({tag, "_hi"}, exp_hi);
  endtask

  task automatic con_chk(input string tag, input logic [1:0] c2, input logic exp);
    load_ir(mk_ir(5'b10011, 4'd2, {2'b00, c2}, 4'd0, 15'd0));
    Gra = 1; Rout = 1; CONIn = 1;
    tick();
    chk(tag, {31'd0, BranchMet}, {31'd0, exp});
  endtask

  initial begin
    clr_ctl();
    Mdatain = '0; InPort_data = '0;
    Clear = 0;
    tick(); tick();
    Clear = 1;

    // Dirty state before reset: PC=5, OutPort=5, CON=1.
    put_in(32'd5);
    InPortout = 1; PCin = 1;
    tick();
    PCout = 1; show("pc_pre", 32'd5);
    CONIn = 1;
    tick();
    chk("con_pre", {31'd0, BranchMet}, 32'd1);

    // One reset edge, with a competing load that must lose.
    Clear = 0; InPortout = 1; PCin = 1;
    tick();
    Clear = 1;
    chk("rst_outp", outp, 32'd0);
    chk("rst_con", {31'd0, BranchMet}, 32'd0);
    PCout = 1;   show("rst_pc", 32'd0);
    Zlowout = 1; show("rst_zlo", 32'd0);
    Zhiout = 1;  show("rst_zhi", 32'd0);
    load_ir(32'hB900_0000);
    Gra = 1; Rout = 1; show("rst_r2", 32'd0);

    // Fetch-style increment: MAR <- PC, Z <- PC+1, PC <- Z.
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    tick();
    Zlowout = 1; PCin = 1;
    tick();
    chk("mar_fetch", dut.mar_q, 32'd0);
    PCout = 1; show("pc_inc", 32'd1);

    // Memory read into MDR, MDR -> HI, HI -> R2.
    Mdatain = 32'd10; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; HIin = 1;
    tick();
    HIout = 1; show("hi", 32'd10);
    load_ir(32'hB900_0000);
    Gra = 1; Rin = 1; HIout = 1;
    tick();
    Gra = 1; Rout = 1; show("r2", 32'd10);

    // ALU operations on R3=5, R4=7, R5=0x80000000.
    load_reg(4'd3, 32'd5);
    load_reg(4'd4, 32'd7);
    load_reg(4'd5, 32'h8000_0000);
    alu_chk("add",  OP_ADD,  4'd3, 4'd4, 32'd12,        32'd0);
    alu_chk("sub",  OP_SUB,  4'd3, 4'd4, 32'hFFFF_FFFE, 32'd0);
    alu_chk("and",  OP_AND,  4'd3, 4'd4, 32'd5,         32'd0);
    alu_chk("or",   OP_OR,   4'd3, 4'd4, 32'd7,         32'd0);
    alu_chk("shl",  OP_SHL,  4'd3, 4'd4, 32'h0000_0280, 32'd0);
    alu_chk("shr",  OP_SHR,  4'd5, 4'd4, 32'h0100_0000, 32'd0);
    alu_chk("shra", OP_SHRA, 4'd5, 4'd4, 32'hFF00_0000, 32'd0);
    alu_chk("ror",  OP_ROR,  4'd3, 4'd4, 32'h0A00_0000, 32'd0);
    alu_chk("rol",  OP_ROL,  4'd3, 4'd4, 32'h0000_0280, 32'd0);
    alu_chk("neg",  OP_NEG,  4'd3, 4'd4, 32'hFFFF_FFF9, 32'd0);
    alu_chk("not",  OP_NOT,  4'd3, 4'd4, 32'hFFFF_FFF8, 32'd0);
    alu_chk("ldadr", 5'b00000, 4'd3, 4'd4, 32'd12,      32'd0);

    load_reg(4'd6, 32'hFFFF_FFFF);
    load_reg(4'd7, 32'd2);
    load_reg(4'd8, 32'd7);
    load_reg(4'd9, 32'd2);
`ifdef MUL_DIV_EN
    alu_chk("mul", OP_MUL, 4'd6, 4'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    alu_chk("div", OP_DIV, 4'd8, 4'd9, 32'd3,         32'd1);
    load_reg(4'd10, 32'd0);
    alu_chk("div0", OP_DIV, 4'd8, 4'd10, 32'd0,       32'd0);
`else
    alu_chk("mul", OP_MUL, 4'd6, 4'd7, 32'd1,         32'd0);
    alu_chk("div", OP_DIV, 4'd8, 4'd9, 32'd9,         32'd0);
`endif

    // Branch condition on R2.
    load_reg(4'd2, 32'd0);
    con_chk("con_eq0_t", CON_ZERO, 1'b1);
    load_reg(4'd2, 32'd3);
    con_chk("con_eq0_f", CON_ZERO, 1'b0);
    con_chk("con_nz_t",  CON_NZ,   1'b1);
    load_reg(4'd2, 32'h8000_0000);
    con_chk("con_neg_t", CON_NEG,  1'b1);
    con_chk("con_pos_f", CON_POS,  1'b0);

    // Sign-extended constant.
    load_ir(mk_ir(5'b00000, 4'd0, 4'd0, 4'b1111, 15'h7FFF));
    Cout = 1; show("c_neg", 32'hFFFF_FFFF);
    load_ir(mk_ir(5'b00000, 4'd0, 4'd0, 4'b0111, 15'h7FFF));
    Cout = 1; show("c_pos", 32'h0003_FFFF);

    // Bus priority and empty bus.
    PCout = 1; InPortout = 1; Zlowout = 1; show("prio_pc", 32'd1);
    MDRout = 1; HIout = 1; show("prio_mdr", 32'd10);
    show("bus_idle", 32'd0);

    // R0 is writable; BAout reads it as 0, Rout does not.
    load_reg(4'd0, 32'd9);
    Gra = 1; Rout = 1;  show("r0_rout", 32'd9);
    Gra = 1; BAout = 1; show("r0_baout", 32'd0);
    load_ir(mk_ir(5'b00000, 4'd0, 4'd3, 4'd0, 15'd0));
    Gra = 1; Grb = 1; Rout = 1; show("rout_low", 32'd9);
    Gra = 1; Grb = 1; BAout = 1; show("baout_r0", 32'd0);

    // Internal RAM write then read back through MDR.
    put_in(32'd3);
    InPortout = 1; MARin = 1;
    tick();
    put_in(32'h0000_DEAD);
    InPortout = 1; MDRin = 1;
    tick();
    Write = 1;
    tick();
    Mdatain = 32'd0; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; show("mdr_ext", 32'd0);
    Read = 1; MemSel = 1; MDRin = 1;
    tick();
    MDRout = 1; show("ram_rd", 32'h0000_DEAD);

    // LO path.
    put_in(32'h1234_5678);
    InPortout = 1; LOin = 1;
    tick();
    LOout = 1; show("lo", 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
